// File: rtl/obi_pkg.sv
// Shared OBI definitions: mux state encoding, timeout error word
// and the response timeout counter width.
package obi_pkg;

    typedef enum logic {
        MUX_IDLE      = 1'b0,
        MUX_WAIT_RESP = 1'b1
    } mux_state_e;

    localparam logic [31:0] OBI_ERR_RDATA = 32'hDEAD_BEEF;
    localparam int unsigned OBI_TMO_W     = 16;

    typedef logic [OBI_TMO_W-1:0] tmo_cnt_t;

endpackage

// File: rtl/obi_mux_4_to_1_if.sv
// One OBI link: address phase plus read response.
// The initiator side uses master, the target side uses slave.
interface obi_mux_4_to_1_if;

    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/obi_rr_arbiter_4.sv
// Four-way round-robin arbiter that keeps a stalled address phase
// with its master until that master is granted.
module obi_rr_arbiter_4 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [3:0] req_i,
    input  logic       gnt_i,
    output logic [1:0] winner_o,
    output logic       winner_valid_o,
    output logic       drop_o
);

    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0] lock_id_q, lock_id_d;
    logic       lock_q, lock_d;
    logic       lock_hit;
    logic [1:0] scan_id;
    logic       scan_valid;

    // Descending scan so the lowest offset from rr_ptr wins.
    always_comb begin
        scan_valid = 1'b0;
        scan_id    = rr_ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (req_i[rr_ptr_q + 2'(i)]) begin
                scan_valid = 1'b1;
                scan_id    = rr_ptr_q + 2'(i);
            end
        end
    end

    assign lock_hit       = lock_q & req_i[lock_id_q];
    assign drop_o         = en_i & lock_q & ~req_i[lock_id_q];
    assign winner_o       = lock_hit ? lock_id_q : scan_id;
    assign winner_valid_o = en_i & (lock_hit | scan_valid);

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (winner_valid_o) begin
            if (gnt_i) begin
                lock_d   = 1'b0;
                rr_ptr_d = winner_o + 2'd1;
            end else begin
                lock_d    = 1'b1;
                lock_id_d = winner_o;
            end
        end else if (drop_o) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q  <= 2'd0;
            lock_q    <= 1'b0;
            lock_id_q <= 2'd0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

endmodule

// File: rtl/obi_mux_4_to_1.sv
// Four-master to one-slave OBI mux with round-robin arbitration,
// one outstanding read and a synthetic response on timeout.
module obi_mux_4_to_1
    import obi_pkg::*;
#(
    parameter int unsigned RESP_TIMEOUT  = 256,
    parameter logic [31:0] TIMEOUT_RDATA = OBI_ERR_RDATA
) (
    input  logic clk_i,
    input  logic rst_i,
    obi_mux_4_to_1_if.slave  ctrl1,
    obi_mux_4_to_1_if.slave  ctrl2,
    obi_mux_4_to_1_if.slave  ctrl3,
    obi_mux_4_to_1_if.slave  ctrl4,
    obi_mux_4_to_1_if.master port,
    output logic bad_state_o
);

    localparam tmo_cnt_t TMO_LAST = tmo_cnt_t'(RESP_TIMEOUT - 1);

    mux_state_e  state_q;
    logic [1:0]  owner_q;
    tmo_cnt_t    tmo_cnt_q;

    logic [3:0]  req_v;
    logic [3:0]  we_v;
    logic [31:0] addr_v  [4];
    logic [3:0]  be_v    [4];
    logic [31:0] wdata_v [4];

    logic        idle;
    logic [1:0]  win;
    logic        win_valid;
    logic        drop;
    logic        hs;
    logic        tmo_hit;
    logic [3:0]  gnt_v;
    logic [3:0]  rvalid_v;
    logic [31:0] rdata;
    logic        p_req;
    logic [31:0] p_addr;
    logic        p_we;
    logic [3:0]  p_be;
    logic [31:0] p_wdata;

    assign req_v = {ctrl4.req, ctrl3.req, ctrl2.req, ctrl1.req};
    assign we_v  = {ctrl4.we, ctrl3.we, ctrl2.we, ctrl1.we};

    assign addr_v[0]  = ctrl1.addr;
    assign addr_v[1]  = ctrl2.addr;
    assign addr_v[2]  = ctrl3.addr;
    assign addr_v[3]  = ctrl4.addr;
    assign be_v[0]    = ctrl1.be;
    assign be_v[1]    = ctrl2.be;
    assign be_v[2]    = ctrl3.be;
    assign be_v[3]    = ctrl4.be;
    assign wdata_v[0] = ctrl1.wdata;
    assign wdata_v[1] = ctrl2.wdata;
    assign wdata_v[2] = ctrl3.wdata;
    assign wdata_v[3] = ctrl4.wdata;

    assign idle = (state_q == MUX_IDLE);

    obi_rr_arbiter_4 u_arb (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .en_i           (idle),
        .req_i          (req_v),
        .gnt_i          (port.gnt),
        .winner_o       (win),
        .winner_valid_o (win_valid),
        .drop_o         (drop)
    );

    assign hs = win_valid & port.gnt;

    // A real response in the expiry cycle takes precedence.
    assign tmo_hit = ~idle & (tmo_cnt_q == TMO_LAST) & ~port.rvalid;

    always_comb begin
        p_req   = win_valid;
        p_addr  = '0;
        p_we    = 1'b0;
        p_be    = '0;
        p_wdata = '0;
        if (win_valid) begin
            p_addr  = addr_v[win];
            p_we    = we_v[win];
            p_be    = be_v[win];
            p_wdata = wdata_v[win];
        end
    end

    always_comb begin
        gnt_v    = '0;
        rvalid_v = '0;
        if (hs)
            gnt_v[win] = 1'b1;
        if (~idle & (port.rvalid | tmo_hit))
            rvalid_v[owner_q] = 1'b1;
    end

    assign rdata       = tmo_hit ? TIMEOUT_RDATA : port.rdata;
    assign bad_state_o = (idle & port.rvalid) | tmo_hit | drop;

    assign port.req   = p_req;
    assign port.addr  = p_addr;
    assign port.we    = p_we;
    assign port.be    = p_be;
    assign port.wdata = p_wdata;

    assign ctrl1.gnt    = gnt_v[0];
    assign ctrl2.gnt    = gnt_v[1];
    assign ctrl3.gnt    = gnt_v[2];
    assign ctrl4.gnt    = gnt_v[3];
    assign ctrl1.rvalid = rvalid_v[0];
    assign ctrl2.rvalid = rvalid_v[1];
    assign ctrl3.rvalid = rvalid_v[2];
    assign ctrl4.rvalid = rvalid_v[3];
    assign ctrl1.rdata  = rdata;
    assign ctrl2.rdata  = rdata;
    assign ctrl3.rdata  = rdata;
    assign ctrl4.rdata  = rdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= MUX_IDLE;
            owner_q   <= 2'd0;
            tmo_cnt_q <= '0;
        end else begin
            case (state_q)
                MUX_IDLE: begin
                    if (hs && !we_v[win]) begin
                        state_q   <= MUX_WAIT_RESP;
                        owner_q   <= win;
                        tmo_cnt_q <= '0;
                    end
                end
                MUX_WAIT_RESP: begin
                    if (port.rvalid || tmo_hit)
                        state_q <= MUX_IDLE;
                    else
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                end
                default: state_q <= MUX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obi_mux_4_to_1.sv
// Self-checking bench for obi_mux_4_to_1: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_obi_mux_4_to_1;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    obi_mux_4_to_1_if c1 ();
    obi_mux_4_to_1_if c2 ();
    obi_mux_4_to_1_if c3 ();
    obi_mux_4_to_1_if c4 ();
    obi_mux_4_to_1_if sp ();

    logic [3:0]  req, we;
    logic [31:0] addr  [4];
    logic [31:0] wdata [4];
    logic [3:0]  be    [4];
    logic        pgnt, prv;
    logic [31:0] prdata;
    logic        bad;

    assign c1.req = req[0];   assign c2.req = req[1];
    assign c3.req = req[2];   assign c4.req = req[3];
    assign c1.we = we[0];     assign c2.we = we[1];
    assign c3.we = we[2];     assign c4.we = we[3];
    assign c1.addr = addr[0]; assign c2.addr = addr[1];
    assign c3.addr = addr[2]; assign c4.addr = addr[3];
    assign c1.be = be[0];     assign c2.be = be[1];
    assign c3.be = be[2];     assign c4.be = be[3];
    assign c1.wdata = wdata[0]; assign c2.wdata = wdata[1];
    assign c3.wdata = wdata[2]; assign c4.wdata = wdata[3];
    assign sp.gnt = pgnt;
    assign sp.rvalid = prv;
    assign sp.rdata = prdata;

    wire [3:0]  gnt_v = {c4.gnt, c3.gnt, c2.gnt, c1.gnt};
    wire [3:0]  rv_v  = {c4.rvalid, c3.rvalid, c2.rvalid, c1.rvalid};
    wire [69:0] port_v = {sp.req, sp.addr, sp.we, sp.be, sp.wdata};
    logic [31:0] rd [4];
    assign rd[0] = c1.rdata; assign rd[1] = c2.rdata;
    assign rd[2] = c3.rdata; assign rd[3] = c4.rdata;

    obi_mux_4_to_1 #(.RESP_TIMEOUT(TMO), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut (
        .clk_i (clk), .rst_i (rst),
        .ctrl1 (c1), .ctrl2 (c2), .ctrl3 (c3), .ctrl4 (c4),
        .port (sp), .bad_state_o (bad)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending stalled master, rotating priority start,
    // and an outstanding read tracked as cycles elapsed since its grant.
    int m_ptr, m_lock_id, m_owner, m_elapsed;
    bit m_lock, m_busy;
    int e_win;
    bit e_wv, e_drop, e_tmo, e_bad;
    logic [3:0]  e_gnt, e_rv;
    logic [31:0] e_rdata;
    logic [69:0] e_port;

    task automatic model_reset();
        m_ptr = 0; m_lock = 0; m_lock_id = 0;
        m_busy = 0; m_owner = 0; m_elapsed = 0;
    endtask

    task automatic model_eval();
        e_wv = 0; e_win = 0; e_drop = 0;
        if (!m_busy) begin
            if (m_lock && req[m_lock_id]) begin
                e_wv = 1; e_win = m_lock_id;
            end else begin
                e_drop = m_lock;
                for (int i = 0; i < 4; i++)
                    if (!e_wv && req[(m_ptr + i) % 4]) begin
                        e_wv = 1; e_win = (m_ptr + i) % 4;
                    end
            end
        end
        e_tmo = m_busy && (m_elapsed == TMO) && !prv;
        e_gnt = '0;
        if (e_wv && pgnt) e_gnt[e_win] = 1'b1;
        e_rv = '0;
        if (m_busy && (prv || e_tmo)) e_rv[m_owner] = 1'b1;
        e_rdata = e_tmo ? 32'hDEAD_BEEF : prdata;
        e_bad = e_drop || e_tmo || (!m_busy && prv);
        e_port = '0;
        if (e_wv) e_port = {1'b1, addr[e_win], we[e_win], be[e_win], wdata[e_win]};
    endtask

    task automatic model_tick();
        if (!m_busy) begin
            if (e_wv && pgnt) begin
                m_lock = 0;
                m_ptr = (e_win + 1) % 4;
                if (!we[e_win]) begin
                    m_busy = 1; m_owner = e_win; m_elapsed = 1;
                end
            end else if (e_wv) begin
                m_lock = 1; m_lock_id = e_win;
            end else begin
                m_lock = 0;
            end
        end else if (prv || e_tmo) begin
            m_busy = 0;
        end else begin
            m_elapsed++;
        end
    endtask

    task automatic clear_inputs();
        req = '0; we = '0; pgnt = 0; prv = 0; prdata = '0;
        for (int i = 0; i < 4; i++) begin
            addr[i] = '0; wdata[i] = '0; be[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if (port_v !== 70'd0) begin
            n_err++; $display("FAIL reset_port: got %h want 0", port_v);
        end
        n_cmp++;
        if ({gnt_v, rv_v, bad} !== 9'd0) begin
            n_err++; $display("FAIL reset_outs: got %b want 0", {gnt_v, rv_v, bad});
        end
        next_cycle();
    endtask

    task automatic test_read();
        do_reset();
        req[0] = 1; we[0] = 0; addr[0] = 32'h1000; be[0] = 4'hF; pgnt = 1;
        @(negedge clk);
        n_cmp++;
        if (gnt_v !== 4'b0001 || sp.addr !== 32'h1000 || sp.req !== 1'b1) begin
            n_err++; $display("FAIL read_gnt: got %b/%h want 0001/00001000", gnt_v, sp.addr);
        end
        next_cycle();
        req = '0; pgnt = 0;
        @(negedge clk);
        n_cmp++;
        if (rv_v !== 4'b0000 || sp.req !== 1'b0) begin
            n_err++; $display("FAIL read_wait: got rv %b req %b want 0 0", rv_v, sp.req);
        end
        next_cycle();
        prv = 1; prdata = 32'h1234_5678;
        @(negedge clk);
        n_cmp++;
        if (rv_v !== 4'b0001 || rd[0] !== 32'h1234_5678 || bad !== 1'b0) begin
            n_err++; $display("FAIL read_resp: got %b %h %b want 0001 12345678 0", rv_v, rd[0], bad);
        end
        next_cycle();
        prv = 0;
        @(negedge clk);
        n_cmp++;
        if (rv_v !== 4'b0000 || bad !== 1'b0) begin
            n_err++; $display("FAIL read_after: got %b %b want 0000 0", rv_v, bad);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        req = 4'hF; we = 4'hF; pgnt = 1;
        for (int i = 0; i < 4; i++) addr[i] = 32'h100 * (i + 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp_g = 4'b0001 << (k % 4);
            n_cmp++;
            if (gnt_v !== exp_g || sp.addr !== 32'h100 * ((k % 4) + 1)) begin
                n_err++; $display("FAIL rr_cycle%0d: got %b want %b", k, gnt_v, exp_g);
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        do_reset();
        req = 4'b0010; we = 4'hF;
        addr[0] = 32'h1100; addr[1] = 32'h2000; addr[2] = 32'h3300;
        @(negedge clk);
        n_cmp++;
        if (sp.addr !== 32'h2000 || gnt_v !== 4'b0000) begin
            n_err++; $display("FAIL stall_c0: got %h %b want 00002000 0000", sp.addr, gnt_v);
        end
        next_cycle();
        req = 4'b0111;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (sp.addr !== 32'h2000 || gnt_v !== 4'b0000 || sp.req !== 1'b1) begin
                n_err++; $display("FAIL stall_c%0d: got %h %b want 00002000 0000", k, sp.addr, gnt_v);
            end
            next_cycle();
        end
        pgnt = 1;
        @(negedge clk);
        n_cmp++;
        if (gnt_v !== 4'b0010 || sp.addr !== 32'h2000) begin
            n_err++; $display("FAIL stall_gnt: got %b %h want 0010 00002000", gnt_v, sp.addr);
        end
        next_cycle();
        req = 4'b0101;
        @(negedge clk);
        n_cmp++;
        if (gnt_v !== 4'b0100) begin
            n_err++; $display("FAIL stall_next: got %b want 0100", gnt_v);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0100; we = 4'b0000; addr[2] = 32'h3000; pgnt = 1;
        @(negedge clk);
        n_cmp++;
        if (gnt_v !== 4'b0100) begin
            n_err++; $display("FAIL tmo_gnt: got %b want 0100", gnt_v);
        end
        next_cycle();
        req = 4'b0001; we[0] = 1; addr[0] = 32'h10;
        for (int k = 1; k < TMO; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({gnt_v, rv_v, bad} !== 9'd0) begin
                n_err++; $display("FAIL tmo_wait%0d: got %b want 0", k, {gnt_v, rv_v, bad});
            end
            next_cycle();
        end
        @(negedge clk);
        n_cmp++;
        if (rv_v !== 4'b0100 || rd[2] !== 32'hDEAD_BEEF || rd[0] !== 32'hDEAD_BEEF || bad !== 1'b1 || gnt_v !== 4'b0) begin
            n_err++; $display("FAIL tmo_fire: got %b %h %b want 0100 deadbeef 1", rv_v, rd[2], bad);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (gnt_v !== 4'b0001 || bad !== 1'b0 || rv_v !== 4'b0) begin
            n_err++; $display("FAIL tmo_next: got %b %b want 0001 0", gnt_v, bad);
        end
        next_cycle();
    endtask

    task automatic test_timeout_race();
        do_reset();
        req = 4'b0010; we = 4'b0000; pgnt = 1;
        next_cycle();
        req = '0; pgnt = 0;
        repeat (TMO - 1) next_cycle();
        prv = 1; prdata = 32'hCAFE_0001;
        @(negedge clk);
        n_cmp++;
        if (rv_v !== 4'b0010 || rd[1] !== 32'hCAFE_0001 || bad !== 1'b0) begin
            n_err++; $display("FAIL race: got %b %h %b want 0010 cafe0001 0", rv_v, rd[1], bad);
        end
        next_cycle();
        prv = 0;
    endtask

    task automatic test_spurious();
        do_reset();
        prv = 1; prdata = 32'h5555_AAAA;
        @(negedge clk);
        n_cmp++;
        if (bad !== 1'b1 || rv_v !== 4'b0 || rd[3] !== 32'h5555_AAAA) begin
            n_err++; $display("FAIL spurious: got %b %b want 1 0000", bad, rv_v);
        end
        next_cycle();
        prv = 0;
        @(negedge clk);
        n_cmp++;
        if (bad !== 1'b0) begin
            n_err++; $display("FAIL spurious_end: got %b want 0", bad);
        end
        next_cycle();
    endtask

    task automatic test_rst_mid_read();
        do_reset();
        req = 4'b0001; we = 4'b0000; pgnt = 1;
        next_cycle();
        req = 4'b1000; we[3] = 1; addr[3] = 32'h4444;
        @(negedge clk);
        n_cmp++;
        if (gnt_v !== 4'b0000 || sp.req !== 1'b0) begin
            n_err++; $display("FAIL rst_wait: got %b %b want 0000 0", gnt_v, sp.req);
        end
        rst = 1;
        next_cycle();
        rst = 0; prv = 1;
        @(negedge clk);
        n_cmp++;
        if (gnt_v !== 4'b1000 || bad !== 1'b1 || rv_v !== 4'b0) begin
            n_err++; $display("FAIL rst_after: got %b %b %b want 1000 1 0000", gnt_v, bad, rv_v);
        end
        next_cycle();
        prv = 0;
    endtask

    task automatic test_random();
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                req[i] = ($urandom_range(0, 2) != 0);
                we[i] = $urandom_range(0, 1);
                addr[i] = $urandom;
                wdata[i] = $urandom;
                be[i] = 4'($urandom);
            end
            pgnt = ($urandom_range(0, 2) != 0);
            prv = m_busy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
            prdata = $urandom;
            @(negedge clk);
            model_eval();
            n_cmp++;
            if (port_v !== e_port) begin
                n_err++; $display("FAIL rnd_port c%0d: got %h want %h", c, port_v, e_port);
            end
            n_cmp++;
            if (gnt_v !== e_gnt) begin
                n_err++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, gnt_v, e_gnt);
            end
            n_cmp++;
            if (rv_v !== e_rv) begin
                n_err++; $display("FAIL rnd_rvalid c%0d: got %b want %b", c, rv_v, e_rv);
            end
            for (int m = 0; m < 4; m++) begin
                n_cmp++;
                if (rd[m] !== e_rdata) begin
                    n_err++; $display("FAIL rnd_rdata%0d c%0d: got %h want %h", m, c, rd[m], e_rdata);
                end
            end
            n_cmp++;
            if (bad !== e_bad) begin
                n_err++; $display("FAIL rnd_bad c%0d: got %b want %b", c, bad, e_bad);
            end
            model_tick();
            next_cycle();
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_read();
        test_round_robin();
        test_stall();
        test_timeout();
        test_timeout_race();
        test_spurious();
        test_rst_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
